// File: rtl/vga_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_reader
// Purpose  : Read-side consumer of the PRU colour-map FIFO. Generates VGA
//            timing on the pixel clock, issues one FIFO read per active
//            pixel, registers the returned RGB onto the VGA pins with
//            sync/blank aligned to it, and repays reads lost to FIFO
//            underflow during vertical blanking so every frame consumes
//            exactly H_ACTIVE*V_ACTIVE reads.
// Options  : VGA_TEST_PATTERN_EN - adds test_sel input; when high, active
//            pixels show 8 vertical colour bars 80 px wide.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan_reader #(
  parameter int              H_ACTIVE = 640,
  parameter int              H_FP     = 16,
  parameter int              H_SYNC   = 96,
  parameter int              H_BP     = 48,
  parameter int              V_ACTIVE = 480,
  parameter int              V_FP     = 10,
  parameter int              V_SYNC   = 2,
  parameter int              V_BP     = 33,
  parameter int              DW       = 10,
  parameter int              PIX_LAT  = 1,   // read-to-data latency, 1..3
  parameter logic [3*DW-1:0] UF_COLOR = '0   // {b,g,r} for underflowed pixels
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          fifo_empty,
  input  logic [DW-1:0] pix_r,
  input  logic [DW-1:0] pix_g,
  input  logic [DW-1:0] pix_b,
`ifdef VGA_TEST_PATTERN_EN
  input  logic          test_sel,
`endif
  output logic          vga_read,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_blank_n,
  output logic [DW-1:0] vga_r,
  output logic [DW-1:0] vga_g,
  output logic [DW-1:0] vga_b,
  output logic          frame_start,
  input  logic          uf_clr,
  output logic [15:0]   underflow_cnt,
  output logic [18:0]   deficit
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [18:0]   DEF_MAX  = 19'(H_ACTIVE * V_ACTIVE);
  localparam logic [15:0]   UCNT_MAX = 16'hFFFF;

  // Pipeline word: [0] hsync window, [1] vsync window, [2] visible,
  // [3] underflow tag, optionally [6:4] colour-bar index.
`ifdef VGA_TEST_PATTERN_EN
  localparam int PW = 7;
`else
  localparam int PW = 4;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_run;
  logic [HW-1:0]   r_h;
  logic [VW-1:0]   r_v;
  logic            w_frame_end;
  logic            w_active;
  logic            w_blank_line;
  logic            w_vis;
  logic            w_uf;
  logic            w_read_act;
  logic            w_repay;
  logic            w_hs_on;
  logic            w_vs_on;
  logic [PW-1:0]   w_stage;
  logic [PW-1:0]   r_pipe [PIX_LAT];
  logic [PW-1:0]   w_tail;
  logic [3*DW-1:0] w_rgb;

  // Scan-position decode; everything below is a function of registered state
  // plus the live fifo_empty flag.
  assign w_frame_end  = (r_h == H_LAST) && (r_v == V_LAST);
  assign w_active     = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_blank_line = (r_v >= V_ACT);
  assign w_vis        = w_run && w_active;
  assign w_uf         = w_vis && fifo_empty;
  assign w_read_act   = w_vis && !fifo_empty;
  assign w_repay      = w_run && w_blank_line && (deficit != 19'd0) && !fifo_empty;
  assign w_hs_on      = (r_h >= HS_BEG) && (r_h < HS_END);
  assign w_vs_on      = (r_v >= VS_BEG) && (r_v < VS_END);

  assign vga_read     = w_read_act || w_repay;
  assign frame_start  = w_run && (r_h == '0) && (r_v == '0);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state; leaving RUN is only considered on the last clock of a frame.
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) w_state_nxt = ST_PRIME;
      end
      ST_PRIME: begin
        if (!enable)         w_state_nxt = ST_IDLE;
        else if (!fifo_empty) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_run = 1'b1;
        if (w_frame_end && !enable) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Scan counters: held at the origin outside RUN, free-running inside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (!w_run) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  // Outstanding-read ledger: grows on underflow, shrinks on each blanking read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deficit <= '0;
    end else if (w_uf && (deficit != DEF_MAX)) begin
      deficit <= deficit + 19'd1;
    end else if (w_repay) begin
      deficit <= deficit - 19'd1;
    end
  end

  // Underflow event counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_cnt <= '0;
    end else if (uf_clr) begin
      underflow_cnt <= '0;
    end else if (w_uf && (underflow_cnt != UCNT_MAX)) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0] w_h10;
  logic [2:0] w_bar;
  assign w_h10   = 10'(r_h);
  assign w_bar   = 3'(w_h10 / 10'd80);
  assign w_stage = {w_bar, w_uf, w_vis, w_vs_on, w_hs_on};
`else
  assign w_stage = {w_uf, w_vis, w_vs_on, w_hs_on};
`endif

  // Delay timing/tag by the FIFO read latency so they meet the returned data.
  // Sync bits are stored active-high so a cleared pipe means "no sync".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIX_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_stage;
      for (int i = 1; i < PIX_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_tail = r_pipe[PIX_LAT-1];

  // Colour select: FIFO data, underflow colour, or black outside active video.
  always_comb begin
    w_rgb = '0;
    if (w_tail[2]) begin
      if (w_tail[3]) w_rgb = UF_COLOR;
      else           w_rgb = {pix_b, pix_g, pix_r};
`ifdef VGA_TEST_PATTERN_EN
      if (test_sel) w_rgb = {{DW{w_tail[6]}}, {DW{w_tail[5]}}, {DW{w_tail[4]}}};
`endif
    end
  end

  // Output register: sync, blank and colour leave together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else begin
      vga_hs      <= !w_tail[0];
      vga_vs      <= !w_tail[1];
      vga_blank_n <= w_tail[2];
      vga_r       <= w_rgb[DW-1:0];
      vga_g       <= w_rgb[2*DW-1:DW];
      vga_b       <= w_rgb[3*DW-1:2*DW];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scan_reader
// Purpose  : Self-checking bench for vga_scan_reader using a shrunken raster
//            (24x11 total, 16x6 active) and a read latency of 2. A FIFO
//            emulator answers the DUT's reads; a frame-position model
//            predicts reads, frame_start, counters and pins every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scan_reader;

  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3, HT = HA + HFP + HSY + HBP;
  localparam int VA = 6,  VFP = 1, VSY = 2, VBP = 2, VT = VA + VFP + VSY + VBP;
  localparam int FRAME   = HT * VT;
  localparam int LAT     = 2;
  localparam int DEF_MAX = HA * VA;
  localparam logic [29:0] UFC  = {10'h3C3, 10'h0F0, 10'h00F};
  localparam logic [29:0] JUNK = {10'h1F0, 10'h1F0, 10'h1F0};

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, fifo_empty = 1'b1, uf_clr = 1'b0;
  logic [9:0] pix_r = '0, pix_g = '0, pix_b = '0;
  logic vga_read, vga_hs, vga_vs, vga_blank_n, frame_start;
  logic [9:0] vga_r, vga_g, vga_b;
  logic [15:0] underflow_cnt;
  logic [18:0] deficit;
`ifdef VGA_TEST_PATTERN_EN
  logic test_sel = 1'b0;
`endif

  always #5 clk = ~clk;

  vga_scan_reader #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .DW(10), .PIX_LAT(LAT), .UF_COLOR(UFC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
`ifdef VGA_TEST_PATTERN_EN
    .test_sel(test_sel),
`endif
    .vga_read(vga_read), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start), .uf_clr(uf_clr),
    .underflow_cnt(underflow_cnt), .deficit(deficit)
  );

  int checks = 0, failures = 0;

  // Model: position within the frame plus running/armed flags and ledgers.
  bit m_run, m_armed;
  int m_pos, m_def, m_ucnt;
  int m_rdidx = 0;   // reads the model expects so far
  int f_idx   = 0;   // reads the FIFO emulator has served
  logic [32:0] exp_q[$];   // {hs,vs,blank_n,rgb} expected at the pins
  logic [29:0] pix_q[$];   // FIFO data in flight

  int n_reads, n_blank_reads, n_fs, n_hs_low, n_vs_low, n_bn, n_uf_pix;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [29:0] fdata(input int n);
    logic [9:0] r, g, b;
    int n7;
    n7 = n * 7;
    r  = n[9:0];
    g  = n[9:0] ^ 10'h2AA;
    b  = n7[9:0];
    return {b, g, r};
  endfunction

  task automatic clr_stats();
    n_reads = 0; n_blank_reads = 0; n_fs = 0;
    n_hs_low = 0; n_vs_low = 0; n_bn = 0; n_uf_pix = 0;
  endtask

  task automatic model_reset();
    m_run = 0; m_armed = 0; m_pos = 0; m_def = 0; m_ucnt = 0;
    exp_q.delete();
    repeat (LAT + 1) exp_q.push_back({1'b1, 1'b1, 1'b0, 30'h0});
    pix_q.delete();
    repeat (LAT) pix_q.push_back(JUNK);
  endtask

  // One pixel clock: called at a falling edge, returns at the next one.
  task automatic tick(input logic en, input logic fe, input logic clr);
    logic [32:0] e;
    logic [29:0] px, rgb_e;
    logic hs_e, vs_e;
    int h, v;
    bit act, uf, rd, fs;
    e = exp_q.pop_front();
    chk("pins{hs,vs,blank_n,rgb}", {vga_hs, vga_vs, vga_blank_n, vga_b, vga_g, vga_r}, e);
    chk("underflow_cnt", underflow_cnt, m_ucnt[15:0]);
    chk("deficit", deficit, m_def[18:0]);
    if (!vga_hs) n_hs_low++;
    if (!vga_vs) n_vs_low++;
    if (vga_blank_n) n_bn++;
    if (vga_blank_n && ({vga_b, vga_g, vga_r} == UFC)) n_uf_pix++;

    enable = en; fifo_empty = fe; uf_clr = clr;
    #1;
    h   = m_pos % HT;
    v   = m_pos / HT;
    act = m_run && (h < HA) && (v < VA);
    uf  = act && fe;
    rd  = m_run && !fe && (act || (v >= VA && m_def > 0));
    fs  = m_run && (m_pos == 0);
    chk("vga_read", vga_read, rd);
    chk("frame_start", frame_start, fs);
    if (vga_read) n_reads++;
    if (vga_read && v >= VA) n_blank_reads++;
    if (frame_start) n_fs++;

    // FIFO emulator answers the DUT's actual reads LAT clocks later.
    if (vga_read) begin
      pix_q.push_back(fdata(f_idx));
      f_idx++;
    end else begin
      pix_q.push_back(JUNK);
    end
    px = pix_q.pop_front();
    {pix_b, pix_g, pix_r} = px;

    // Pins for this scan slot appear LAT+1 clocks later.
    rgb_e = 30'h0;
    if (act) rgb_e = uf ? UFC : fdata(m_rdidx);
    hs_e = !((h >= HA + HFP) && (h < HA + HFP + HSY));
    vs_e = !((v >= VA + VFP) && (v < VA + VFP + VSY));
    exp_q.push_back({hs_e, vs_e, act, rgb_e});
    if (rd) m_rdidx++;

    if (uf && m_def < DEF_MAX) m_def++;
    else if (rd && v >= VA) m_def--;
    if (clr) m_ucnt = 0;
    else if (uf && m_ucnt < 65535) m_ucnt++;

    if (m_run) begin
      if (m_pos == FRAME - 1) begin
        m_pos = 0;
        if (!en) m_run = 0;
      end else begin
        m_pos++;
      end
    end else if (m_armed) begin
      if (!en) m_armed = 0;
      else if (!fe) begin
        m_run = 1; m_armed = 0;
      end
    end else if (en) begin
      m_armed = 1;
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with enable high.
    rst_n = 1'b0; enable = 1'b1; fifo_empty = 1'b0; uf_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset pins", {vga_hs, vga_vs, vga_blank_n, vga_b, vga_g, vga_r}, {3'b110, 30'h0});
    chk("reset read/fs", {vga_read, frame_start}, 2'b00);
    chk("reset counts", {underflow_cnt, deficit}, 35'h0);
    rst_n = 1'b1;
    model_reset();

    // Prime gating: FIFO empty keeps the scan parked.
    clr_stats();
    repeat (50) tick(1'b1, 1'b1, 1'b0);
    chk("prime no frame_start", n_fs, 0);
    chk("prime no reads", n_reads, 0);

    // FIFO fills: scan starts on the next clock with a read.
    tick(1'b1, 1'b0, 1'b0);
    chk("first frame_start", frame_start, 1'b1);
    chk("first read", vga_read, 1'b1);

    // Nominal frame.
    clr_stats();
    repeat (FRAME) tick(1'b1, 1'b0, 1'b0);
    chk("nominal reads/frame", n_reads, 96);
    chk("nominal frame_start count", n_fs, 1);
    chk("nominal hs low clocks", n_hs_low, 33);
    chk("nominal vs low clocks", n_vs_low, 48);
    chk("nominal blank_n high clocks", n_bn, 96);

    // Underflow on pixels h=5..9 of line 0, repaid at the start of line VA.
    clr_stats();
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b1, (m_pos >= 5 && m_pos <= 9) ? 1'b1 : 1'b0, 1'b0);
      if (m_pos == HT) chk("uf after line 0 {ucnt,deficit}", {underflow_cnt, deficit}, {16'd5, 19'd5});
    end
    chk("uf frame reads", n_reads, 96);
    chk("uf frame repay reads", n_blank_reads, 5);
    chk("uf frame uf_color pixels", n_uf_pix, 5);
    chk("uf frame deficit repaid", deficit, 19'd0);
    chk("uf frame frame_start count", n_fs, 1);

    // uf_clr on the same clock as an underflow.
    clr_stats();
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b1, (m_pos == HT) ? 1'b1 : 1'b0, (m_pos == HT) ? 1'b1 : 1'b0);
      if (m_pos == HT + 1) chk("uf_clr collision {ucnt,deficit}", {underflow_cnt, deficit}, {16'd0, 19'd1});
    end
    chk("collision frame reads", n_reads, 96);

    // Two fully starved frames: deficit saturates at the frame size.
    repeat (2 * FRAME) tick(1'b1, 1'b1, 1'b0);
    chk("saturated deficit", deficit, 19'd96);
    chk("starved ucnt", underflow_cnt, 16'd192);

    // Recovery frame repays the whole deficit during blanking.
    clr_stats();
    repeat (FRAME) tick(1'b1, 1'b0, 1'b0);
    chk("recovery reads", n_reads, 192);
    chk("recovery deficit", deficit, 19'd0);

    // Disable mid-frame: the frame completes, then the scan stops.
    clr_stats();
    for (int i = 0; i < FRAME; i++) tick((m_pos < 3 * HT) ? 1'b1 : 1'b0, 1'b0, 1'b0);
    chk("disable frame reads", n_reads, 96);
    clr_stats();
    repeat (30) tick(1'b0, 1'b0, 1'b0);
    chk("idle reads", n_reads, 0);
    chk("idle frame_start", n_fs, 0);
    chk("idle pins", {vga_hs, vga_vs, vga_blank_n, vga_b, vga_g, vga_r}, {3'b110, 30'h0});

    // PRIME falls back to IDLE when enable drops.
    clr_stats();
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    repeat (2) tick(1'b1, 1'b1, 1'b0);
    chk("prime abort frame_start", n_fs, 0);

    // Restart and abort mid-line with an asynchronous reset.
    for (int i = 0; i < 100; i++) begin
      if (m_run && m_pos == HT + 6) break;
      tick(1'b1, 1'b0, 1'b0);
    end
    chk("blank_n before reset", vga_blank_n, 1'b1);
    chk("ucnt before reset", underflow_cnt, 16'd192);
    rst_n = 1'b0;
    #1;
    chk("async reset pins", {vga_hs, vga_vs, vga_blank_n, vga_b, vga_g, vga_r}, {3'b110, 30'h0});
    chk("async reset read/fs", {vga_read, frame_start}, 2'b00);
    chk("async reset counts", {underflow_cnt, deficit}, 35'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
